// File: rtl/bcd_serial_ctrl_if.sv
// Request/result bundle between a requester and the serial BCD add/subtract controller.
interface bcd_serial_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  sub;
    logic [4*DIGITS-1:0]   op_a;
    logic [4*DIGITS-1:0]   op_b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  err;

    modport master (
        output start, sub, op_a, op_b,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, sub, op_a, op_b,
        output busy, done, sum, cout, err
    );
endinterface

// File: rtl/bcd_serial_ctrl.sv
// Multi-digit BCD add/subtract controller: one shared digit adder, LSD first, one digit per clock.
// IDLE: wait for start | ADD: one digit per cycle | DONE: one-cycle result-valid pulse
module bcd_serial_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    bcd_serial_ctrl_if.slave   bus
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = $clog2(DIGITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               sub_q, sub_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               err_q, err_d;

    logic [3:0]         dig_a;
    logic [3:0]         dig_b;
    logic [3:0]         b_eff;
    logic [4:0]         t_raw;
    logic [4:0]         t_adj;
    logic [3:0]         dig_res;
    logic               dig_carry;
    logic               in_invalid;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Single digit adder stage shared across all digit positions
    always_comb begin
        dig_a = 4'd0;
        dig_b = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                dig_a = a_q[4*i +: 4];
                dig_b = b_q[4*i +: 4];
            end
        end
        b_eff = sub_q ? (4'd9 - dig_b) : dig_b;
        t_raw = {1'b0, dig_a} + {1'b0, b_eff} + {4'd0, carry_q};
        t_adj = t_raw + 5'd6;
        if (t_raw > 5'd9) begin
            dig_res   = t_adj[3:0];
            dig_carry = 1'b1;
        end else begin
            dig_res   = t_raw[3:0];
            dig_carry = 1'b0;
        end
    end

    assign in_invalid = has_bad_digit(bus.op_a) | has_bad_digit(bus.op_b);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    sub_d   = bus.sub;
                    carry_d = bus.sub;
                    idx_d   = '0;
                    sum_d   = '0;
                    err_d   = in_invalid;
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[4*i +: 4] = dig_res;
                    end
                end
                carry_d = dig_carry;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = dig_carry;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy = (state_q == ADD);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.err  = err_q;
endmodule
